mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: sequences fetch/decode/execute with memory wait timeout trapping.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_control_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_s;
    logic             is_load_r;
    logic             in_wait_s;
    logic             timeout_s;

    function automatic logic rtype_ok(input logic [5:0] f);
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: rtype_ok = 1'b1;
            default:                           rtype_ok = 1'b0;
        endcase
    endfunction

    assign state     = state_r;
    assign in_wait_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign timeout_s = (wait_cnt_r == CNT_LAST);

    // Next-state selection; mem_ready wins over an expiring wait counter
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready)      state_s = S_DECODE;
                else if (timeout_s) state_s = S_TRAP;
                else                state_s = S_FETCH;
            end
            S_DECODE: begin
                if ((opcode == 6'h00) && rtype_ok(funct))     state_s = S_EXEC;
                else if ((opcode == 6'h23) || (opcode == 6'h2B)) state_s = S_MEMADR;
                else if (opcode == 6'h04)                     state_s = S_BRANCH;
                else if (opcode == 6'h02)                     state_s = S_JUMP;
                else if (opcode == 6'h08)                     state_s = S_ADDIEX;
                else                                          state_s = S_TRAP;
            end
            S_MEMADR: begin
                if (is_load_r) state_s = S_MEMRD;
                else           state_s = S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready)      state_s = S_MEMWB;
                else if (timeout_s) state_s = S_TRAP;
                else                state_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready)      state_s = S_FETCH;
                else if (timeout_s) state_s = S_TRAP;
                else                state_s = S_MEMWR;
            end
            S_MEMWB:  state_s = S_FETCH;
            S_EXEC:   state_s = S_ALUWB;
            S_ALUWB:  state_s = S_FETCH;
            S_BRANCH: state_s = S_FETCH;
            S_JUMP:   state_s = S_FETCH;
            S_ADDIEX: state_s = S_ADDIWB;
            S_ADDIWB: state_s = S_FETCH;
            S_TRAP:   state_s = S_TRAP;
            default:  state_s = S_TRAP;
        endcase
    end

    // Wait counter restarts on every state change, so entry to a wait state sees zero
    always_comb begin
        wait_cnt_s = wait_cnt_r;
        if (state_s != state_r) begin
            wait_cnt_s = {CNT_W{1'b0}};
        end else if (in_wait_s && !mem_ready) begin
            wait_cnt_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // State, wait counter and latched load/store selector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= {CNT_W{1'b0}};
            is_load_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (state_r == S_DECODE) begin
                is_load_r <= (opcode == 6'h23);
            end else begin
                is_load_r <= is_load_r;
            end
        end
    end

    // Datapath controls decoded from the current state; handshake-qualified strobes use mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        instr_done    = 1'b0;
        trap          = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    // Retired-instruction and non-trap cycle counters, free-running with natural wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            if (instr_done) begin
                instr_count <= instr_count + 32'd1;
            end else begin
                instr_count <= instr_count;
            end
            if (state_r != S_TRAP) begin
                cycle_count <= cycle_count + 32'd1;
            end else begin
                cycle_count <= cycle_count;
            end
        end
    end
`endif

endmodule
